lsu: RTL
========

# lsu

Multi-cycle load/store and write-back unit sitting between the decode/execute stage and the register-file write port. Accepts one decoded operation per handshake (load encoding, unshifted store mask, store data, effective address, ALU result), runs the memory transaction on a valid/ready request bus with a separate response channel, and drives the registered write-back triple `w_regW`/`w_regAddr`/`w_regData` consumed by the register file. Also performs sub-word lane alignment, load sign/zero extension and misalignment detection.

## Interface
- `ADDR_WIDTH`, 32, address width
- `DATA_WIDTH`, 32, data width (lane logic fixed at 4 byte lanes)
- `REG_ADDR_WIDTH`, 5, register index width
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset; asynchronous, active-high
- `in_valid`  in  1  operation offered
- `in_ready`  out  1  operation accepted when `in_valid & in_ready`
- `in_addr`  in  ADDR_WIDTH  effective address (ALU result for memory ops)
- `in_alu_result`  in  DATA_WIDTH  write-back value for non-memory ops
- `in_load_inst`  in  3  000 none, 001 lb, 010 lh, 011 lw, 100 lbu, 101 lhu; 110/111 = none
- `in_store_mask`  in  4  0000 none, 0001 sb, 0011 sh, 1111 sw (unshifted)
- `in_store_data`  in  DATA_WIDTH  rs2 value, unshifted
- `in_regW`, `in_regAddr`  in  1 / REG_ADDR_WIDTH  decoded write enable / rd
- `mem_req_valid`  out  1; `mem_req_ready`  in  1
- `mem_req_addr`  out  ADDR_WIDTH  word-aligned (`in_addr & ~3`)
- `mem_req_wen`  out  1  1 = store
- `mem_req_wmask`  out  4  byte strobes, shifted
- `mem_req_wdata`  out  DATA_WIDTH  lane-shifted store data
- `mem_resp_valid`  in  1  response (read data or write ack); no backpressure
- `mem_resp_rdata`  in  DATA_WIDTH  full aligned word
- `w_regW`, `w_regAddr`, `w_regData`  out  1 / REG_ADDR_WIDTH / DATA_WIDTH  write-back, one-cycle pulse
- `misalign_err`  out  1  one-cycle pulse on misaligned access

## Operation
- States: IDLE, REQ, WAIT. `in_ready = (state==IDLE) & ~rst`.
- IDLE accept, classification by priority: load (`in_load_inst` ∈ 001..101) > store (`in_store_mask`≠0) > non-memory.
- Non-memory: next cycle `w_regW = in_regW & (in_regAddr≠0)`, `w_regData = in_alu_result`; stay IDLE.
- Misaligned: lh/lhu/sh with `addr[0]`=1; lw/sw with `addr[1:0]`≠0. Next cycle `misalign_err`=1, no write-back, no bus request; stay IDLE.
- Aligned memory op: latch all inputs, → REQ.
- REQ: `mem_req_valid`=1, request fields stable until `mem_req_ready`; on handshake → WAIT.
- Store fields: `wmask = mask << addr[1:0]`; `wdata = store_data << (8*addr[1:0])`; `wen`=1. Load: `wen`=0, `wmask`=0000.
- WAIT: on `mem_resp_valid` → IDLE. Load: `w_regW = regW & (rd≠0)` next cycle with extracted data; store: no write-back.
- Extraction: `s = rdata >> (8*addr[1:0])`; lb = sext(s[7:0]); lbu = zext(s[7:0]); lh = sext(s[15:0]); lhu = zext(s[15:0]); lw = rdata.
- `mem_resp_valid` in IDLE or REQ is ignored (stale/post-reset responses dropped).
- All write-back and `misalign_err` outputs registered; zero in every cycle without an event.

## Timing
- Reset (async, immediate): state IDLE; `mem_req_valid`, `w_regW`, `misalign_err` = 0; `w_regAddr`, `w_regData`, `mem_req_*` data = 0; `in_ready` = 0 while `rst`=1, 1 the first cycle after release.
- Reset mid-transaction: request withdrawn same instant; no write-back; late response ignored.
- Non-memory op: write-back cycle after acceptance; throughput 1/cycle.
- Memory op, accepted at cycle 0: `mem_req_valid` from cycle 1; handshake at cycle h ≥ 1; response at cycle r ≥ h+1; write-back and `in_ready`=1 at cycle r+1. Minimum load latency 3 cycles.
- Response earliest one cycle after request handshake; same-cycle response is out of protocol and ignored.
- Write-back of op N and acceptance of op N+1 may coincide.

## Test plan
- Non-memory: back-to-back accepts, rd=5 value 0x1234, rd=0 value 0xFFFF → `w_regW`=1 rd5 0x1234 next cycle, then `w_regW`=0 for rd0; `in_ready` stays 1.
- lb at 0x8000_0003, rdata 0x80FF_0000, rd=7 → req addr 0x8000_0000, wen=0; `w_regData`=0xFFFF_FF80 cycle after response; same with lbu → 0x0000_0080.
- sh at 0x1002, data 0xABCD_1234, `mem_req_ready` low 3 cycles → wmask 1100, wdata 0x1234_0000 held stable; no write-back after ack.
- sw at 0x1001 → `misalign_err` pulse next cycle, `mem_req_valid` never rises, `in_ready` stays 1.
- Load in WAIT, assert `rst` for 1 cycle, then drive `mem_resp_valid` → outputs zeroed immediately, no write-back, next op accepted normally.
- lh at 0x2002, rdata 0x8001_7FFF → `w_regData`=0xFFFF_8001; lhu → 0x0000_8001.

Source files
------------

// File: rtl/lsu.sv
// Load/store and write-back unit: accepts one decoded op per handshake, runs the
// memory transaction on a valid/ready request bus and drives registered write-back.
module lsu #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ADDR_WIDTH-1:0]     in_addr,
    input  logic [DATA_WIDTH-1:0]     in_alu_result,
    input  logic [2:0]                in_load_inst,
    input  logic [3:0]                in_store_mask,
    input  logic [DATA_WIDTH-1:0]     in_store_data,
    input  logic                      in_regW,
    input  logic [REG_ADDR_WIDTH-1:0] in_regAddr,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic [ADDR_WIDTH-1:0]     mem_req_addr,
    output logic                      mem_req_wen,
    output logic [3:0]                mem_req_wmask,
    output logic [DATA_WIDTH-1:0]     mem_req_wdata,
    input  logic                      mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]     mem_resp_rdata,
    output logic                      w_regW,
    output logic [REG_ADDR_WIDTH-1:0] w_regAddr,
    output logic [DATA_WIDTH-1:0]     w_regData,
    output logic                      misalign_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t state, state_next;

    logic                      accept;
    logic                      is_load;
    logic                      is_store;
    logic                      misaligned;
    logic [2:0]                ld_inst_q;
    logic [1:0]                off_q;
    logic                      is_load_q;
    logic                      regW_q;
    logic [REG_ADDR_WIDTH-1:0] regAddr_q;
    logic [DATA_WIDTH-1:0]     shifted;
    logic [DATA_WIDTH-1:0]     load_value;

    assign in_ready      = (state == IDLE) & ~rst;
    assign accept        = in_valid & in_ready;
    assign mem_req_valid = (state == REQ);

    always_comb begin
        is_load    = (in_load_inst >= 3'd1) && (in_load_inst <= 3'd5);
        is_store   = ~is_load && (in_store_mask != 4'b0000);
        misaligned = 1'b0;
        if (is_load) begin
            if ((in_load_inst == 3'd2) || (in_load_inst == 3'd5))
                misaligned = in_addr[0];
            else if (in_load_inst == 3'd3)
                misaligned = (in_addr[1:0] != 2'b00);
        end else if (is_store) begin
            if (in_store_mask[3])
                misaligned = (in_addr[1:0] != 2'b00);
            else if (in_store_mask[1])
                misaligned = in_addr[0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept && (is_load || is_store) && !misaligned) state_next = REQ;
            REQ:  if (mem_req_ready) state_next = WAIT;
            WAIT: if (mem_resp_valid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A word-aligned load leaves offset 0, so the shifted word is the raw word for lw.
    always_comb begin
        shifted    = mem_resp_rdata >> {off_q, 3'b000};
        load_value = shifted;
        case (ld_inst_q)
            3'd1: load_value = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
            3'd2: load_value = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
            3'd4: load_value = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
            3'd5: load_value = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
            default: load_value = shifted;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_inst_q     <= '0;
            off_q         <= '0;
            is_load_q     <= 1'b0;
            regW_q        <= 1'b0;
            regAddr_q     <= '0;
            mem_req_addr  <= '0;
            mem_req_wen   <= 1'b0;
            mem_req_wmask <= '0;
            mem_req_wdata <= '0;
            w_regW        <= 1'b0;
            w_regAddr     <= '0;
            w_regData     <= '0;
            misalign_err  <= 1'b0;
        end else begin
            w_regW       <= 1'b0;
            w_regAddr    <= '0;
            w_regData    <= '0;
            misalign_err <= 1'b0;
            if (accept) begin
                if (is_load || is_store) begin
                    if (misaligned) begin
                        misalign_err <= 1'b1;
                    end else begin
                        ld_inst_q     <= in_load_inst;
                        off_q         <= in_addr[1:0];
                        is_load_q     <= is_load;
                        regW_q        <= in_regW;
                        regAddr_q     <= in_regAddr;
                        mem_req_addr  <= {in_addr[ADDR_WIDTH-1:2], 2'b00};
                        mem_req_wen   <= is_store;
                        mem_req_wmask <= is_store ? (in_store_mask << in_addr[1:0]) : 4'b0000;
                        mem_req_wdata <= is_store ? (in_store_data << {in_addr[1:0], 3'b000}) : '0;
                    end
                end else begin
                    w_regW    <= in_regW && (in_regAddr != '0);
                    w_regAddr <= in_regAddr;
                    w_regData <= in_alu_result;
                end
            end else if ((state == WAIT) && mem_resp_valid && is_load_q) begin
                w_regW    <= regW_q && (regAddr_q != '0);
                w_regAddr <= regAddr_q;
                w_regData <= load_value;
            end
        end
    end

endmodule
